// File: rtl/wtm_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : wtm_product_accumulator
// Brief    : Sums a programmed number of signed multiplier products into a
//            guard-extended accumulator; returns one saturated result per job.
// Revision : 1.0 - initial release
// ============================================================================
module wtm_product_accumulator #(
    parameter int PW = 64,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          p_valid,
    input  logic [PW-1:0] p_data,
    output logic          p_ready,
    output logic [PW-1:0] acc_out,
    output logic          ovf,
    output logic          done,
    output logic          busy
);

    localparam int            c_AW      = PW + LW;
    localparam logic [PW-1:0] c_MAX_POS = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] c_MAX_NEG = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_AW-1:0] r_acc;
    logic [LW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc_out;
    logic            r_ovf;
    logic            r_done;

    logic            w_accept;
    logic [LW:0]     w_hi;
    logic            w_in_range;
    logic [PW-1:0]   w_sat;

    assign w_accept = (r_state == S_ACC) && p_valid;

    // The value fits in PW bits exactly when all guard bits match the PW sign bit.
    assign w_hi       = r_acc[c_AW-1:PW-1];
    assign w_in_range = (&w_hi) | ~(|w_hi);
    assign w_sat      = w_in_range ? r_acc[PW-1:0]
                                   : (r_acc[c_AW-1] ? c_MAX_NEG : c_MAX_POS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_FIN : S_ACC;
            S_ACC:   if (w_accept && (r_cnt == LW'(1))) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_out <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_cnt <= len;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + {{LW{p_data[PW-1]}}, p_data};
                        r_cnt <= r_cnt - LW'(1);
                    end
                end
                S_FIN: begin
                    r_acc_out <= w_sat;
                    r_ovf     <= ~w_in_range;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign p_ready = (r_state == S_ACC);
    assign busy    = (r_state != S_IDLE);
    assign acc_out = r_acc_out;
    assign ovf     = r_ovf;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wtm_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wtm_product_accumulator
// Brief    : Self-checking bench for wtm_product_accumulator against a
//            wide-integer reference model of the job sum and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wtm_product_accumulator;

    localparam logic signed [127:0] c_MAXP = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] c_MINN = -128'sh8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        p_valid = 1'b0;
    logic [63:0] p_data = '0;
    logic        p_ready;
    logic [63:0] acc_out;
    logic        ovf;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [63:0] q_prod[$];
    int          q_gap[$];

    wtm_product_accumulator #(.PW(64), .LW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .p_valid (p_valid),
        .p_data  (p_data),
        .p_ready (p_ready),
        .acc_out (acc_out),
        .ovf     (ovf),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference: exact sum in a wide integer, then clamp to the 64-bit range.
    function automatic logic [64:0] model_result();
        logic signed [127:0] s;
        logic signed [127:0] t;
        s = '0;
        foreach (q_prod[i]) begin
            t = $signed(q_prod[i]);
            s = s + t;
        end
        if (s > c_MAXP)      return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        else if (s < c_MINN) return {1'b1, 64'h8000_0000_0000_0000};
        else                 return {1'b0, s[63:0]};
    endfunction

    function automatic int gap_total();
        int g;
        g = 0;
        foreach (q_gap[i]) g += q_gap[i];
        return g;
    endfunction

    // Drives one job from q_prod/q_gap and measures it; called aligned #1 after an edge.
    task automatic run_job(output logic [63:0] got, output logic got_ovf,
                           output int lat, output int bad_hs, output logic pulse_ok);
        int e;
        bad_hs = 0;
        start = 1'b1;
        len   = 8'(q_prod.size());
        @(posedge clk); #1;
        start = 1'b0;
        e = 1;
        foreach (q_prod[i]) begin
            for (int g = 0; g < q_gap[i]; g++) begin
                @(posedge clk); #1;
                e++;
                if (busy !== 1'b1 || p_ready !== 1'b1) bad_hs++;
            end
            if (p_ready !== 1'b1) bad_hs++;
            p_valid = 1'b1;
            p_data  = q_prod[i];
            @(posedge clk); #1;
            e++;
            p_valid = 1'b0;
            p_data  = $urandom();
        end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            e++;
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
        got     = acc_out;
        got_ovf = ovf;
        @(posedge clk); #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0) && (p_ready === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({acc_out, ovf, done, busy, p_ready} !== 68'd0) begin
            fails++;
            $display("FAIL reset_state: got acc=%h ovf=%b done=%b busy=%b rdy=%b required all 0",
                     acc_out, ovf, done, busy, p_ready);
        end
        rst = 1'b1;
        p_valid = 1'b1;
        p_data  = 64'd99;
        @(posedge clk); #1;
        p_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || p_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_valid: busy=%b rdy=%b done=%b required 0 0 0", busy, p_ready, done);
        end
    endtask

    task automatic test_mixed_signs();
        logic [63:0] got; logic g_ovf, pok; int lat, bad;
        q_prod = {64'd1500, 64'd2064, 64'hFFFF_FFFF_FFFF_FEA7, 64'hFFFF_FFFF_FFFF_FD12};
        q_gap  = {0, 0, 0, 0};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'd2469 || g_ovf !== 1'b0) begin
            fails++;
            $display("FAIL mixed_signs: got %h ovf=%b required %h ovf=0", got, g_ovf, 64'd2469);
        end
        tests++;
        if (lat !== 6) begin
            fails++;
            $display("FAIL mixed_latency: got %0d edges required 6", lat);
        end
        tests++;
        if (!pok || bad != 0) begin
            fails++;
            $display("FAIL mixed_pulse: pulse_ok=%b handshake_errs=%0d required 1 and 0", pok, bad);
        end
    endtask

    task automatic test_stalls();
        logic [63:0] got; logic g_ovf, pok; int lat, bad;
        q_prod = {64'd2500, 64'hFFFF_FFFF_FFFF_F736, 64'd10};
        q_gap  = {0, 2, 5};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'd260 || g_ovf !== 1'b0) begin
            fails++;
            $display("FAIL stalls_value: got %h ovf=%b required %h ovf=0", got, g_ovf, 64'd260);
        end
        tests++;
        if (bad != 0 || lat !== 12) begin
            fails++;
            $display("FAIL stalls_busy: handshake_errs=%0d latency=%0d required 0 and 12", bad, lat);
        end
        q_prod = {};
        q_gap  = {};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'd0 || lat !== 2 || g_ovf !== 1'b0 || !pok) begin
            fails++;
            $display("FAIL empty_job: got %h lat=%0d ovf=%b pulse=%b required 0 lat=2 ovf=0 pulse=1",
                     got, lat, g_ovf, pok);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] got; logic g_ovf, pok; int lat, bad;
        q_prod = {64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
                  64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
        q_gap  = {0, 0, 0, 0};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'h7FFF_FFFF_FFFF_FFFF || g_ovf !== 1'b1) begin
            fails++;
            $display("FAIL pos_sat: got %h ovf=%b required 7fffffffffffffff ovf=1", got, g_ovf);
        end
        q_prod = {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        q_gap  = {0, 0};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'h8000_0000_0000_0000 || g_ovf !== 1'b1) begin
            fails++;
            $display("FAIL neg_sat: got %h ovf=%b required 8000000000000000 ovf=1", got, g_ovf);
        end
        q_prod = {64'd0};
        q_gap  = {0};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'd0 || g_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %h ovf=%b required 0 ovf=0", got, g_ovf);
        end
    endtask

    task automatic test_reset_midjob();
        logic [63:0] got; logic g_ovf, pok; int lat, bad;
        q_prod = {64'd777};
        q_gap  = {0};
        run_job(got, g_ovf, lat, bad, pok);
        start = 1'b1;
        len   = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_valid = 1'b1;
            p_data  = 64'd1000 + 64'(i);
            @(posedge clk); #1;
        end
        p_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({acc_out, ovf, done, busy, p_ready} !== 68'd0) begin
            fails++;
            $display("FAIL async_reset: got acc=%h ovf=%b done=%b busy=%b rdy=%b required all 0",
                     acc_out, ovf, done, busy, p_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        q_prod = {64'd1500};
        q_gap  = {0};
        run_job(got, g_ovf, lat, bad, pok);
        tests++;
        if (got !== 64'd1500 || g_ovf !== 1'b0 || lat !== 3) begin
            fails++;
            $display("FAIL post_reset_job: got %h ovf=%b lat=%0d required %h ovf=0 lat=3",
                     got, g_ovf, lat, 64'd1500);
        end
    endtask

    task automatic test_start_handling();
        int e;
        logic seen;
        start = 1'b1;
        len   = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        e = 1;
        p_valid = 1'b1; p_data = 64'd100;
        @(posedge clk); #1; e++;
        p_valid = 1'b0;
        start = 1'b1; len = 8'd7;
        @(posedge clk); #1; e++;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || p_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_in_acc_state: busy=%b rdy=%b required 1 1", busy, p_ready);
        end
        p_valid = 1'b1; p_data = 64'd200;
        @(posedge clk); #1; e++;
        p_data = 64'd300;
        @(posedge clk); #1; e++;
        p_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; e++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || e !== 6 || acc_out !== 64'd600) begin
            fails++;
            $display("FAIL start_in_acc_ignored: done_seen=%b lat=%0d acc=%h required 1 6 %h",
                     seen, e, acc_out, 64'd600);
        end
        // Back-to-back: request the next job in the done cycle.
        start = 1'b1; len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_done: busy=%b done=%b required 1 0", busy, done);
        end
        p_valid = 1'b1; p_data = 64'hFFFF_FFFF_FFFF_FFFD;
        @(posedge clk); #1;
        p_data = 64'd10;
        @(posedge clk); #1;
        p_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || acc_out !== 64'd7) begin
            fails++;
            $display("FAIL back_to_back: done_seen=%b acc=%h required 1 %h", seen, acc_out, 64'd7);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] got; logic g_ovf, pok; int lat, bad, n;
        logic [64:0] exp_r;
        for (int j = 0; j < 12; j++) begin
            q_prod = {};
            q_gap  = {};
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       q_prod.push_back(64'($signed($urandom())));
                    1:       q_prod.push_back({$urandom(), $urandom()});
                    2:       q_prod.push_back(64'h7FFF_FFFF_FFFF_FFF0 - 64'($urandom_range(0, 99)));
                    default: q_prod.push_back(64'h8000_0000_0000_0000 + 64'($urandom_range(0, 99)));
                endcase
                q_gap.push_back($urandom_range(0, 2));
            end
            exp_r = model_result();
            run_job(got, g_ovf, lat, bad, pok);
            tests++;
            if (got !== exp_r[63:0] || g_ovf !== exp_r[64] || lat !== n + 2 + gap_total()
                || bad != 0 || !pok) begin
                fails++;
                $display("FAIL random_job%0d: got %h ovf=%b lat=%0d required %h ovf=%b lat=%0d",
                         j, got, g_ovf, lat, exp_r[63:0], exp_r[64], n + 2 + gap_total());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mixed_signs();
        test_stalls();
        test_saturation();
        test_reset_midjob();
        test_start_handling();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
